ysyx_25060170_gpr_sb: RTL
=========================

# ysyx_25060170_gpr_sb

Parametrised general-purpose register file with an integrated writeback scoreboard, the next-generation GPR for the pipelined core. It provides NRD combinational read ports, one registered writeback port with optional same-cycle bypass, and a per-register busy bit. Decode marks a destination busy when it issues; writeback clears the bit. Decode stalls on RAW hazards via `rd_busy` and on WAW hazards via `iss_ready`.

## Interface
- XLEN, 32, register width in bits
- NREG, 32, number of architectural registers; 16 (RV32E) or 32; AW = $clog2(NREG)
- NRD, 3, number of read ports
- BYPASS, 1, 1 = writeback data forwarded to read ports in the same cycle
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k source is pending (post-bypass)
- iss_valid  in  1  decode requests to mark iss_rd busy
- iss_rd  in  AW  destination being issued
- iss_ready  out  1  issue accepted this cycle
- wb_valid  in  1  writeback request
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- wb_ready  out  1  writeback accepted; equals rst (high whenever out of reset)
- flush  in  1  clear all busy bits (pipeline squash)
- busy_vec  out  NREG  current busy bits, bit 0 always 0
- busy_cnt  out  AW+1  registered population count of busy_vec

## Operation
- Storage: registers 1..NREG-1 of XLEN bits. Register 0 reads 0, is never written, and is never busy.
- Fire conditions: iss_fire = iss_valid & iss_ready; wb_fire = wb_valid & wb_ready.
- Reset (rst=0 at the edge): all registers = 0, busy_vec = 0, busy_cnt = 0. While rst=0: iss_ready = 0, wb_ready = 0, and rd_data reflects the stored values.
- Read (combinational), port k:
  - If BYPASS and wb_fire and wb_rd == rd_addr[k] != 0: rd_data = wb_data, rd_busy = 0.
  - Otherwise: rd_data = stored value and rd_busy = busy[rd_addr[k]].
- iss_ready = rst & ~flush & (iss_rd == 0 | ~busy[iss_rd] | (wb_fire & wb_rd == iss_rd)).
  - Issue to a busy register stalls (WAW) unless that register is being written back in the same cycle.
- Writeback: on wb_fire with wb_rd != 0, the register takes wb_data at the edge and busy[wb_rd] clears. A writeback to a non-busy register still writes; busy stays 0. wb_rd == 0 is a no-op.
- Issue: on iss_fire with iss_rd != 0, busy[iss_rd] sets at the edge. Issue to x0 is accepted and changes nothing.
- Same register, same cycle: if wb_fire and iss_fire target the same register, the data is written and busy ends set (the issue wins).
- flush: at the edge all busy bits clear. A writeback in the same cycle still writes its data. iss_ready = 0 during the flush cycle. Flush has priority over any busy set.
- busy_cnt equals the popcount of next-state busy_vec, registered. It never exceeds NREG-1.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, the stored state, and the wb bypass).
- Written data is visible from stored state one cycle after wb_fire. With BYPASS, it is also visible in the wb_fire cycle.
- A busy bit set by iss_fire is visible in busy_vec/rd_busy the next cycle. A cleared bit is visible in the same cycle via bypass (BYPASS=1), otherwise the next cycle.
- busy_vec and busy_cnt always update together on the same edge.
- Reset asserted mid-operation discards pending busy bits and data at that edge; no writeback is accepted in that cycle.
- No combinational path runs from iss_valid to iss_ready, or from wb_valid to wb_ready.

## Test plan
- Reset then read: hold rst=0 for 2 cycles, release, read x0..x31 on all ports -> all 0; busy_vec=0; busy_cnt=0; wb_ready=1.
- Write/read/bypass: wb x5=0xDEADBEEF while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle (BYPASS=1), stored the next cycle. With BYPASS=0 -> old value 0 in the same cycle, new value the next cycle.
- x0 protection: wb x0=0xFFFFFFFF plus issue x0 -> read x0=0, busy_vec[0]=0, iss_ready=1.
- RAW/WAW: issue x7 -> next cycle rd_busy=1 for a port reading x7 and busy_cnt=1. A second issue x7 -> iss_ready=0. Then wb x7=0x1234 -> busy clears, busy_cnt=0.
- Same-cycle issue+wb on x9 (x9 busy) -> iss_ready=1, x9=wb_data, busy[9] stays 1, busy_cnt unchanged.
- Flush: issue x1, x2, x3 -> busy_cnt=3. Assert flush with wb x2=0x55 -> next cycle busy_vec=0, busy_cnt=0, x2=0x55. Repeat with NREG=16 and check busy_vec width is 16.

Source files
------------

// File: rtl/ysyx_25060170_gpr_sb.sv
// GPR file with an integrated writeback scoreboard: NRD combinational read ports,
// one registered writeback port with optional same-cycle bypass, and per-register busy bits.
module ysyx_25060170_gpr_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 3,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  wb_ready,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_vec,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            wb_fire, iss_fire;

    assign wb_ready  = rst;
    assign wb_fire   = wb_valid & wb_ready;
    // A busy destination may be reissued only when it retires in the same cycle.
    assign iss_ready = rst & ~flush &
                       ((iss_rd == '0) | ~busy_q[iss_rd] | (wb_fire & (wb_rd == iss_rd)));
    assign iss_fire  = iss_valid & iss_ready;

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          byp;
        assign a   = rd_addr[k*AW +: AW];
        assign byp = (BYPASS != 0) && wb_fire && (wb_rd == a) && (a != '0);
        assign rd_data[k*XLEN +: XLEN] = byp ? wb_data : regs_q[a];
        assign rd_busy[k]              = byp ? 1'b0 : busy_q[a];
    end

    // Issue is applied after writeback so a same-register pair leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wb_fire)  busy_d[wb_rd]  = 1'b0;
        if (iss_fire) busy_d[iss_rd] = 1'b1;
        if (flush)    busy_d = '0;
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 1; i < NREG; i++) cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (wb_fire && (wb_rd != '0)) regs_q[wb_rd] <= wb_data;
        end
    end

endmodule
